// File: rtl/reorder_buffer.sv
// ----------------------------------------------------------------------------
// reorder_buffer
//   In-order-commit reorder buffer sitting between issue and register
//   writeback. Each issued instruction is granted a tag (the tail slot).
//   Results and exceptions arrive out of order by tag and are retired
//   strictly in program order from the head over a valid/ready port.
//
// Ports
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   flush_i                 synchronous clear of all entries (highest priority)
//   alloc_valid_i/_dest_i   allocation request and its destination register
//   alloc_ready_o/_tag_o    buffer not full / tag granted to the request
//   wb_valid_i, wb_tag_i    writeback strobe and entry being completed
//   wb_result_i             result value
//   wb_exception_i/_vector_i exception flag and vector
//   commit_valid_o          head entry complete and retirable
//   commit_ready_i          consumer accepts the head entry
//   commit_dest_o/_regwr_o  head destination / head writes the register file
//   commit_result_o         head result
//   commit_exception_o/_vector_o head exception flag and vector
//   count_o                 occupied entries, 0..ROB_DEPTH
// ----------------------------------------------------------------------------
module reorder_buffer #(
   parameter int XLEN      = 32,
   parameter int ROB_DEPTH = 64,
   parameter int ROB_ADDR  = $clog2(ROB_DEPTH),
   parameter int REG_ADDR  = $clog2(XLEN),
   parameter int EXC_WIDTH = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 alloc_valid_i,
   input  logic [REG_ADDR-1:0]  alloc_dest_i,
   output logic                 alloc_ready_o,
   output logic [ROB_ADDR-1:0]  alloc_tag_o,
   input  logic                 wb_valid_i,
   input  logic [ROB_ADDR-1:0]  wb_tag_i,
   input  logic [XLEN-1:0]      wb_result_i,
   input  logic                 wb_exception_i,
   input  logic [EXC_WIDTH-1:0] wb_vector_i,
   output logic                 commit_valid_o,
   input  logic                 commit_ready_i,
   output logic [REG_ADDR-1:0]  commit_dest_o,
   output logic                 commit_regwr_o,
   output logic [XLEN-1:0]      commit_result_o,
   output logic                 commit_exception_o,
   output logic [EXC_WIDTH-1:0] commit_vector_o,
   output logic [ROB_ADDR:0]    count_o
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [ROB_ADDR:0]    head;
   logic [ROB_ADDR:0]    tail;
   logic [ROB_ADDR-1:0]  head_idx;
   logic [ROB_ADDR-1:0]  tail_idx;

   logic [ROB_DEPTH-1:0] valid;
   logic [ROB_DEPTH-1:0] done;

   // Payload storage is never reset; valid/done qualify it.
   logic [REG_ADDR-1:0]  dest_mem   [ROB_DEPTH];
   logic [XLEN-1:0]      result_mem [ROB_DEPTH];
   logic                 exc_mem    [ROB_DEPTH];
   logic [EXC_WIDTH-1:0] vec_mem    [ROB_DEPTH];

   logic empty;
   logic full;
   logic alloc_fire;
   logic wb_fire;
   logic commit_fire;

   assign head_idx = head[ROB_ADDR-1:0];
   assign tail_idx = tail[ROB_ADDR-1:0];

   assign empty = (head == tail);
   assign full  = (head_idx == tail_idx) && (head[ROB_ADDR] != tail[ROB_ADDR]);

   // Ready is a function of the registered pointers only, so a commit in a
   // full cycle does not free the slot for allocation until the next cycle.
   assign alloc_ready_o = !full;
   assign alloc_tag_o   = tail_idx;
   assign count_o       = tail - head;

   assign alloc_fire  = alloc_valid_i && !full;
   assign wb_fire     = wb_valid_i && valid[wb_tag_i];
   assign commit_fire = commit_valid_o && commit_ready_i;

   // done is sampled from registers: a writeback to the head becomes
   // visible here only on the following cycle.
   assign commit_valid_o     = !empty && done[head_idx];
   assign commit_dest_o      = dest_mem[head_idx];
   assign commit_result_o    = result_mem[head_idx];
   assign commit_exception_o = exc_mem[head_idx];
   assign commit_vector_o    = vec_mem[head_idx];
   assign commit_regwr_o     = (dest_mem[head_idx] != '0) && !exc_mem[head_idx];

   // Control state: pointers and per-entry valid/done.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head  <= '0;
         tail  <= '0;
         valid <= '0;
         done  <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         valid <= '0;
         done  <= '0;
      end else begin
         if (alloc_fire) begin
            valid[tail_idx] <= 1'b1;
            done[tail_idx]  <= 1'b0;
            tail            <= tail + 1'b1;
         end
         if (wb_fire) begin
            done[wb_tag_i] <= 1'b1;
         end
         // Placed last so retiring the head wins over a same-cycle rewrite of it.
         if (commit_fire) begin
            valid[head_idx] <= 1'b0;
            done[head_idx]  <= 1'b0;
            head            <= head + 1'b1;
         end
      end
   end

   // Payload writes; last writeback to a valid entry wins.
   always_ff @(posedge clk_i) begin
      if (!flush_i && alloc_fire) begin
         dest_mem[tail_idx] <= alloc_dest_i;
      end
      if (!flush_i && wb_fire) begin
         result_mem[wb_tag_i] <= wb_result_i;
         exc_mem[wb_tag_i]    <= wb_exception_i;
         vec_mem[wb_tag_i]    <= wb_vector_i;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// ----------------------------------------------------------------------------
// tb_reorder_buffer
//   Self-checking bench for reorder_buffer. A ROB_DEPTH=4 instance is driven
//   by directed sequences and random traffic, checked every cycle against a
//   program-order queue model. A ROB_DEPTH=64 instance is streamed through
//   100 alloc/writeback/commit cycles to exercise tag wrap-around.
// ----------------------------------------------------------------------------
module tb_reorder_buffer;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DEPTH=4 instance signals ----------------
   logic        flush = 0;
   logic        alloc_valid = 0;
   logic [4:0]  alloc_dest = 0;
   logic        alloc_ready;
   logic [1:0]  alloc_tag;
   logic        wb_valid = 0;
   logic [1:0]  wb_tag = 0;
   logic [31:0] wb_result = 0;
   logic        wb_exception = 0;
   logic [3:0]  wb_vector = 0;
   logic        commit_valid;
   logic        commit_ready = 0;
   logic [4:0]  commit_dest;
   logic        commit_regwr;
   logic [31:0] commit_result;
   logic        commit_exception;
   logic [3:0]  commit_vector;
   logic [2:0]  count;

   reorder_buffer #(.XLEN(32), .ROB_DEPTH(DEPTH), .EXC_WIDTH(4)) u_dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .alloc_valid_i(alloc_valid), .alloc_dest_i(alloc_dest),
      .alloc_ready_o(alloc_ready), .alloc_tag_o(alloc_tag),
      .wb_valid_i(wb_valid), .wb_tag_i(wb_tag), .wb_result_i(wb_result),
      .wb_exception_i(wb_exception), .wb_vector_i(wb_vector),
      .commit_valid_o(commit_valid), .commit_ready_i(commit_ready),
      .commit_dest_o(commit_dest), .commit_regwr_o(commit_regwr),
      .commit_result_o(commit_result), .commit_exception_o(commit_exception),
      .commit_vector_o(commit_vector), .count_o(count)
   );

   // ---------------- DEPTH=64 instance signals ----------------
   logic        alloc_valid64 = 0;
   logic [4:0]  alloc_dest64 = 0;
   logic        alloc_ready64;
   logic [5:0]  alloc_tag64;
   logic        wb_valid64 = 0;
   logic [5:0]  wb_tag64 = 0;
   logic [31:0] wb_result64 = 0;
   logic        commit_valid64;
   logic        commit_ready64 = 0;
   logic [4:0]  commit_dest64;
   logic        commit_regwr64;
   logic [31:0] commit_result64;
   logic        commit_exception64;
   logic [3:0]  commit_vector64;
   logic [6:0]  count64;
   logic        flush64 = 0;
   logic        wb_exception64 = 0;
   logic [3:0]  wb_vector64 = 0;

   reorder_buffer #(.XLEN(32), .ROB_DEPTH(64), .EXC_WIDTH(4)) u_dut64 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush64),
      .alloc_valid_i(alloc_valid64), .alloc_dest_i(alloc_dest64),
      .alloc_ready_o(alloc_ready64), .alloc_tag_o(alloc_tag64),
      .wb_valid_i(wb_valid64), .wb_tag_i(wb_tag64), .wb_result_i(wb_result64),
      .wb_exception_i(wb_exception64), .wb_vector_i(wb_vector64),
      .commit_valid_o(commit_valid64), .commit_ready_i(commit_ready64),
      .commit_dest_o(commit_dest64), .commit_regwr_o(commit_regwr64),
      .commit_result_o(commit_result64), .commit_exception_o(commit_exception64),
      .commit_vector_o(commit_vector64), .count_o(count64)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- program-order reference model ----------------
   typedef struct {
      int          tag;
      logic [4:0]  dest;
      bit          done;
      logic [31:0] res;
      bit          exc;
      logic [3:0]  vec;
   } ent_t;

   ent_t q[$];
   int   next_tag = 0;

   task automatic model_clear();
      q.delete();
      next_tag = 0;
   endtask

   task automatic check_outputs(input string tag);
      bit exp_cv;
      exp_cv = (q.size() > 0) && q[0].done;
      check({tag, "_ready"}, alloc_ready, (q.size() < DEPTH));
      check({tag, "_tag"},   alloc_tag,   next_tag);
      check({tag, "_count"}, count,       q.size());
      check({tag, "_cvalid"}, commit_valid, exp_cv);
      if (exp_cv) begin
         check({tag, "_cdest"},  commit_dest,      q[0].dest);
         check({tag, "_cres"},   commit_result,    q[0].res);
         check({tag, "_cexc"},   commit_exception, q[0].exc);
         check({tag, "_cvec"},   commit_vector,    q[0].vec);
         check({tag, "_cregwr"}, commit_regwr,     (q[0].dest != 0) && !q[0].exc);
      end
   endtask

   // One clock: check pre-edge outputs, drive, clock, advance the model.
   task automatic cycle(input string tag, input bit av, input int ad,
                        input bit wv, input int wt, input logic [31:0] wr,
                        input bit we, input logic [3:0] wvec,
                        input bit cr, input bit fl);
      bit   cfire, afire;
      ent_t e;
      @(negedge clk);
      check_outputs(tag);
      alloc_valid  = av;  alloc_dest = ad[4:0];
      wb_valid     = wv;  wb_tag = wt[1:0]; wb_result = wr;
      wb_exception = we;  wb_vector = wvec;
      commit_ready = cr;  flush = fl;
      @(posedge clk);
      if (fl) begin
         model_clear();
      end else begin
         cfire = cr && (q.size() > 0) && q[0].done;
         afire = av && (q.size() < DEPTH);
         if (wv) begin
            foreach (q[i]) begin
               if (q[i].tag == wt) begin
                  q[i].done = 1; q[i].res = wr; q[i].exc = we; q[i].vec = wvec;
               end
            end
         end
         if (cfire) void'(q.pop_front());
         if (afire) begin
            e.tag = next_tag; e.dest = ad[4:0]; e.done = 0;
            e.res = 0; e.exc = 0; e.vec = 0;
            q.push_back(e);
            next_tag = (next_tag + 1) % DEPTH;
         end
      end
   endtask

   task automatic idle(input string tag, input bit cr);
      cycle(tag, 0, 0, 0, 0, 0, 0, 0, cr, 0);
   endtask

   initial begin
      // ---------------- reset ----------------
      rst = 1'b1;
      #12;
      check("rst_ready", alloc_ready, 1);
      check("rst_tag", alloc_tag, 0);
      check("rst_cvalid", commit_valid, 0);
      check("rst_count", count, 0);
      rst = 1'b0;
      model_clear();

      // 1. in-order commit of out-of-order results
      cycle("t1a", 1, 5, 0, 0, 0, 0, 0, 0, 0);
      cycle("t1a", 1, 6, 0, 0, 0, 0, 0, 0, 0);
      cycle("t1a", 1, 7, 0, 0, 0, 0, 0, 0, 0);
      cycle("t1w", 0, 0, 1, 1, 32'h11, 0, 0, 1, 0);
      cycle("t1w", 0, 0, 1, 0, 32'h10, 0, 0, 1, 0);
      repeat (3) idle("t1c", 1);
      cycle("t1f", 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // 2. fill, extra alloc ignored, one commit, wrap to tag 0
      repeat (5) cycle("t2a", 1, 9, 0, 0, 0, 0, 0, 0, 0);
      cycle("t2w", 0, 0, 1, 0, 32'hABCD, 0, 0, 0, 0);
      cycle("t2c", 1, 3, 0, 0, 0, 0, 0, 1, 0);
      cycle("t2n", 1, 4, 0, 0, 0, 0, 0, 0, 0);
      idle("t2e", 0);
      cycle("t2f", 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // 3. exception blocks regwr; dest 0 blocks regwr
      cycle("t3a", 1, 3, 0, 0, 0, 0, 0, 0, 0);
      cycle("t3a", 1, 0, 1, 0, 32'h55, 1, 4'b0000, 0, 0);
      cycle("t3w", 0, 0, 1, 1, 32'h66, 0, 4'b1010, 0, 0);
      repeat (3) idle("t3c", 1);

      // 4. backpressure holds head, then retires in one cycle
      cycle("t4a", 1, 12, 0, 0, 0, 0, 0, 0, 0);
      cycle("t4w", 0, 0, 1, 2, 32'hC0FFEE, 0, 0, 0, 0);
      repeat (3) idle("t4h", 0);
      idle("t4r", 1);
      idle("t4e", 0);

      // 5. simultaneous alloc/wb/commit, then flush with pending entries
      cycle("t5", 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cycle("t5a", 1, 1, 0, 0, 0, 0, 0, 0, 0);
      cycle("t5a", 1, 2, 1, 0, 32'h20, 0, 0, 0, 0);
      cycle("t5s", 1, 3, 1, 1, 32'h21, 0, 0, 1, 0);
      idle("t5k", 0);
      cycle("t5p", 1, 4, 0, 0, 0, 0, 0, 0, 0);
      cycle("t5x", 1, 5, 1, 2, 32'h99, 0, 0, 1, 1);
      cycle("t5o", 0, 0, 1, 1, 32'h77, 0, 0, 1, 0);
      repeat (2) idle("t5z", 1);

      // 6. async reset pulse between edges
      repeat (3) cycle("t6a", 1, 8, 0, 0, 0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      check("t6_ready", alloc_ready, 1);
      check("t6_tag", alloc_tag, 0);
      check("t6_cvalid", commit_valid, 0);
      check("t6_count", count, 0);
      rst = 1'b0;
      model_clear();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         bit          av, wv, we, cr, fl;
         int          wt;
         av = ($urandom_range(0, 9) < 6);
         wv = ($urandom_range(0, 9) < 7);
         if (q.size() > 0 && $urandom_range(0, 9) < 8)
            wt = q[$urandom_range(0, q.size() - 1)].tag;
         else
            wt = $urandom_range(0, DEPTH - 1);
         we = ($urandom_range(0, 9) < 2);
         cr = ($urandom_range(0, 9) < 7);
         fl = ($urandom_range(0, 99) < 2);
         cycle("rnd", av, $urandom_range(0, 31), wv, wt, $urandom,
               we, 4'($urandom_range(0, 15)), cr, fl);
      end
      idle("rnd_end", 0);

      // DEPTH=64 streaming with tag wrap 63 -> 0
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         check("w64_tag", alloc_tag64, k % 64);
         check("w64_ready", alloc_ready64, 1);
         check("w64_count", count64, (k < 2) ? k : 2);
         check("w64_cvalid", commit_valid64, (k >= 2));
         if (k >= 2) check("w64_cres", commit_result64, 32'hA000 + k - 2);
         alloc_valid64  = 1'b1;
         alloc_dest64   = 5'(k % 32);
         wb_valid64     = (k >= 1);
         wb_tag64       = 6'((k + 63) % 64);
         wb_result64    = 32'hA000 + k - 1;
         commit_ready64 = 1'b1;
      end
      @(negedge clk);
      alloc_valid64  = 1'b0;
      wb_valid64     = 1'b0;
      commit_ready64 = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
